// File: rtl/segasys1_hvgen.sv
// Horizontal/vertical video timing generator: pixel counters, blanking, adjustable
// syncs and line/frame strobes, all advancing on the pixel clock enable.
module segasys1_hvgen #(
   parameter int H_TOTAL  = 320,
   parameter int H_VIS    = 256,
   parameter int V_TOTAL  = 264,
   parameter int V_VIS    = 224,
   parameter int HS_START = 280,
   parameter int HS_WIDTH = 32,
   parameter int VS_START = 240,
   parameter int VS_WIDTH = 3
) (
   input  logic       clk40M,
   input  logic       reset_n,
   input  logic       pclk_en,
   input  logic [3:0] hs_adj,
   input  logic [3:0] vs_adj,
   output logic [8:0] PH,
   output logic [8:0] PV,
   output logic       HBLK,
   output logic       VBLK,
   output logic       HSYNC_N,
   output logic       VSYNC_N,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);

   localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
   localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
   localparam logic [8:0] H_VIS_C  = 9'(H_VIS);
   localparam logic [8:0] V_VIS_C  = 9'(V_VIS);
   localparam logic [9:0] HS_BASE  = 10'(HS_START);
   localparam logic [9:0] VS_BASE  = 10'(VS_START);
   localparam logic [9:0] HS_LEN   = 10'(HS_WIDTH);
   localparam logic [9:0] VS_LEN   = 10'(VS_WIDTH);

   logic [3:0] hs_adj_q;
   logic [3:0] vs_adj_q;
   logic       h_wrap;
   logic       v_wrap;
   logic [8:0] ph_nxt;
   logic [8:0] pv_nxt;
   logic [9:0] hs_first;
   logic [9:0] hs_end;
   logic [9:0] vs_first;
   logic [9:0] vs_end;
   logic       hs_act;
   logic       vs_act;

   assign h_wrap = (PH == H_LAST);
   assign v_wrap = h_wrap && (PV == V_LAST);

   always_comb begin
      ph_nxt = PH + 9'd1;
      pv_nxt = PV;
      if (h_wrap) begin
         ph_nxt = 9'd0;
         pv_nxt = v_wrap ? 9'd0 : PV + 9'd1;
      end
   end

   // Sync windows use the adjust latched at the last frame wrap, so a mid-frame
   // change of hs_adj/vs_adj only takes effect from the following frame.
   assign hs_first = HS_BASE + {{6{hs_adj_q[3]}}, hs_adj_q};
   assign hs_end   = hs_first + HS_LEN;
   assign vs_first = VS_BASE + {{6{vs_adj_q[3]}}, vs_adj_q};
   assign vs_end   = vs_first + VS_LEN;
   assign hs_act   = ({1'b0, ph_nxt} >= hs_first) && ({1'b0, ph_nxt} < hs_end);
   assign vs_act   = ({1'b0, pv_nxt} >= vs_first) && ({1'b0, pv_nxt} < vs_end);

   always_ff @(posedge clk40M or negedge reset_n) begin
      if (!reset_n) begin
         PH          <= '0;
         PV          <= '0;
         HBLK        <= 1'b0;
         VBLK        <= 1'b0;
         HSYNC_N     <= 1'b1;
         VSYNC_N     <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
         hs_adj_q    <= '0;
         vs_adj_q    <= '0;
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (pclk_en) begin
            PH      <= ph_nxt;
            PV      <= pv_nxt;
            HBLK    <= (ph_nxt >= H_VIS_C);
            VBLK    <= (pv_nxt >= V_VIS_C);
            HSYNC_N <= ~hs_act;
            if (h_wrap) begin
               VSYNC_N    <= ~vs_act;
               line_start <= 1'b1;
            end
            if (v_wrap) begin
               frame_start <= 1'b1;
               frame_cnt   <= frame_cnt + 8'd1;
               hs_adj_q    <= hs_adj;
               vs_adj_q    <= vs_adj;
            end
         end
      end
   end

endmodule

// File: tb/tb_segasys1_hvgen.sv
// Directed bench for segasys1_hvgen: default timing on one instance, a reduced
// geometry for frame-level sync adjust, and a tiny geometry for frame counter wrap.
module tb_segasys1_hvgen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // default instance
   logic       rst_d, en_d;
   logic [3:0] hadj_d, vadj_d;
   logic [8:0] ph_d, pv_d;
   logic       hblk_d, vblk_d, hsn_d, vsn_d, ls_d, fs_d;
   logic [7:0] fc_d;

   // reduced instance: 24x24, visible 4x4, syncs at 14 width 2
   logic       rst_s, en_s;
   logic [3:0] hadj_s, vadj_s;
   logic [8:0] ph_s, pv_s;
   logic       hblk_s, vblk_s, hsn_s, vsn_s, ls_s, fs_s;
   logic [7:0] fc_s;

   // tiny instance: 4x4 frame, for frame counter wrap
   logic       rst_t, en_t;
   logic [3:0] hadj_t, vadj_t;
   logic [8:0] ph_t, pv_t;
   logic       hblk_t, vblk_t, hsn_t, vsn_t, ls_t, fs_t;
   logic [7:0] fc_t;

   segasys1_hvgen dut_d (
      .clk40M(clk), .reset_n(rst_d), .pclk_en(en_d), .hs_adj(hadj_d), .vs_adj(vadj_d),
      .PH(ph_d), .PV(pv_d), .HBLK(hblk_d), .VBLK(vblk_d), .HSYNC_N(hsn_d), .VSYNC_N(vsn_d),
      .line_start(ls_d), .frame_start(fs_d), .frame_cnt(fc_d));

   segasys1_hvgen #(
      .H_TOTAL(24), .H_VIS(4), .V_TOTAL(24), .V_VIS(4),
      .HS_START(14), .HS_WIDTH(2), .VS_START(14), .VS_WIDTH(2)
   ) dut_s (
      .clk40M(clk), .reset_n(rst_s), .pclk_en(en_s), .hs_adj(hadj_s), .vs_adj(vadj_s),
      .PH(ph_s), .PV(pv_s), .HBLK(hblk_s), .VBLK(vblk_s), .HSYNC_N(hsn_s), .VSYNC_N(vsn_s),
      .line_start(ls_s), .frame_start(fs_s), .frame_cnt(fc_s));

   segasys1_hvgen #(
      .H_TOTAL(4), .H_VIS(2), .V_TOTAL(4), .V_VIS(2),
      .HS_START(2), .HS_WIDTH(1), .VS_START(2), .VS_WIDTH(1)
   ) dut_t (
      .clk40M(clk), .reset_n(rst_t), .pclk_en(en_t), .hs_adj(hadj_t), .vs_adj(vadj_t),
      .PH(ph_t), .PV(pv_t), .HBLK(hblk_t), .VBLK(vblk_t), .HSYNC_N(hsn_t), .VSYNC_N(vsn_t),
      .line_start(ls_t), .frame_start(fs_t), .frame_cnt(fc_t));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // window trackers for the reduced instance
   int hs_min, hs_max, vs_min, vs_max, hb_min, vb_min, fs_n, ls_n, vs_off_wrap;
   logic vsn_prev;

   task automatic clear_track();
      hs_min = 999; hs_max = -1; vs_min = 999; vs_max = -1;
      hb_min = 999; vb_min = 999; fs_n = 0; ls_n = 0; vs_off_wrap = 0;
   endtask

   // back-to-back enables on the reduced instance, one sample per enable
   task automatic run_s(input int n, input bit write_adj);
      @(negedge clk);
      en_s = 1'b1;
      for (int i = 0; i < n; i++) begin
         vsn_prev = vsn_s;
         @(negedge clk);
         if (!hsn_s) begin
            if (int'(ph_s) < hs_min) hs_min = int'(ph_s);
            if (int'(ph_s) > hs_max) hs_max = int'(ph_s);
         end
         if (!vsn_s) begin
            if (int'(pv_s) < vs_min) vs_min = int'(pv_s);
            if (int'(pv_s) > vs_max) vs_max = int'(pv_s);
         end
         if (hblk_s && int'(ph_s) < hb_min) hb_min = int'(ph_s);
         if (vblk_s && int'(pv_s) < vb_min) vb_min = int'(pv_s);
         if (vsn_s !== vsn_prev && ph_s != 9'd0) vs_off_wrap++;
         if (fs_s) fs_n++;
         if (ls_s) ls_n++;
         if (write_adj && pv_s == 9'd10 && ph_s == 9'd0) begin
            hadj_s = 4'b1000;
            vadj_s = 4'b0111;
         end
      end
      en_s = 1'b0;
   endtask

   initial begin
      int d_hs_min, d_hs_max, d_hs_n, d_hb_min, d_hb_n, d_ls_n, chg, strb, fc_bad;
      logic [39:0] snap;
      rst_d = 1'b0; rst_s = 1'b0; rst_t = 1'b0;
      en_d = 1'b0; en_s = 1'b0; en_t = 1'b0;
      hadj_d = '0; vadj_d = '0; hadj_s = '0; vadj_s = '0; hadj_t = '0; vadj_t = '0;
      repeat (3) @(negedge clk);

      chk("d_reset_state", {ph_d, pv_d, hblk_d, vblk_d, hsn_d, vsn_d, ls_d, fs_d, fc_d},
          {9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});

      // one default line, enable every 8th cycle
      rst_d = 1'b1;
      repeat (2) @(negedge clk);
      d_hs_min = 999; d_hs_max = -1; d_hs_n = 0; d_hb_min = 999; d_hb_n = 0; d_ls_n = 0;
      for (int i = 0; i < 320; i++) begin
         en_d = 1'b1;
         @(negedge clk);
         en_d = 1'b0;
         if (i == 0) begin
            chk("d_first_ph", ph_d, 1);
            chk("d_first_no_strobe", {ls_d, fs_d}, 0);
         end
         if (!hsn_d) begin
            d_hs_n++;
            if (int'(ph_d) < d_hs_min) d_hs_min = int'(ph_d);
            if (int'(ph_d) > d_hs_max) d_hs_max = int'(ph_d);
         end
         if (hblk_d) begin
            d_hb_n++;
            if (int'(ph_d) < d_hb_min) d_hb_min = int'(ph_d);
         end
         if (ls_d) d_ls_n++;
         repeat (7) begin
            @(negedge clk);
            if (ls_d) d_ls_n++;
         end
      end
      chk("d_line_wrap_pos", {ph_d, pv_d}, {9'd0, 9'd1});
      chk("d_hsync_first", d_hs_min, 280);
      chk("d_hsync_last", d_hs_max, 311);
      chk("d_hsync_len", d_hs_n, 32);
      chk("d_hblk_first", d_hb_min, 256);
      chk("d_hblk_len", d_hb_n, 64);
      chk("d_line_strobe_cnt", d_ls_n, 1);
      chk("d_line1_vblk_vsync", {vblk_d, vsn_d, fs_d}, {1'b0, 1'b1, 1'b0});

      // advance to PH=150 back-to-back, then hold enable low
      en_d = 1'b1;
      repeat (150) @(negedge clk);
      en_d = 1'b0;
      chk("d_b2b_ph150", {ph_d, pv_d}, {9'd150, 9'd1});
      @(negedge clk);
      snap = {ph_d, pv_d, hblk_d, vblk_d, hsn_d, vsn_d, fc_d, 4'd0};
      chg = 0; strb = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if ({ph_d, pv_d, hblk_d, vblk_d, hsn_d, vsn_d, fc_d, 4'd0} !== snap) chg++;
         if (ls_d || fs_d) strb++;
      end
      chk("d_hold_changes", chg, 0);
      chk("d_hold_strobes", strb, 0);

      // reach PH=150 PV=120, then reset asynchronously between edges
      en_d = 1'b1;
      repeat (119 * 320) @(negedge clk);
      en_d = 1'b0;
      chk("d_pos_150_120", {ph_d, pv_d, hblk_d, vblk_d, hsn_d, vsn_d}, {9'd150, 9'd120, 4'b0011});
      #2 rst_d = 1'b0;
      #1;
      chk("d_async_reset", {ph_d, pv_d, hblk_d, vblk_d, hsn_d, vsn_d, ls_d, fs_d, fc_d},
          {9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
      @(negedge clk);
      rst_d = 1'b1;
      @(negedge clk);
      en_d = 1'b1;
      @(negedge clk);
      en_d = 1'b0;
      chk("d_resume_ph1", {ph_d, pv_d, ls_d, fs_d}, {9'd1, 9'd0, 1'b0, 1'b0});

      // reduced geometry: adjust written mid-frame applies from the next frame
      rst_s = 1'b1;
      @(negedge clk);
      clear_track();
      run_s(576, 1'b1);
      chk("s_f1_pos", {ph_s, pv_s, fc_s}, {9'd0, 9'd0, 8'd1});
      chk("s_f1_frame_start", fs_n, 1);
      chk("s_f1_line_start", ls_n, 24);
      chk("s_f1_hsync", {hs_min[15:0], hs_max[15:0]}, {16'd14, 16'd15});
      chk("s_f1_vsync", {vs_min[15:0], vs_max[15:0]}, {16'd14, 16'd15});
      chk("s_f1_blank_first", {hb_min[15:0], vb_min[15:0]}, {16'd4, 16'd4});
      chk("s_f1_vsync_on_wrap", vs_off_wrap, 0);
      clear_track();
      run_s(576, 1'b0);
      chk("s_f2_hsync", {hs_min[15:0], hs_max[15:0]}, {16'd6, 16'd7});
      chk("s_f2_vsync", {vs_min[15:0], vs_max[15:0]}, {16'd21, 16'd22});
      chk("s_f2_frame_cnt", {fc_s, 8'(fs_n)}, {8'd2, 8'd1});

      // tiny geometry: 256 frames bring frame_cnt back to 0
      rst_t = 1'b1;
      @(negedge clk);
      fs_n = 0; fc_bad = 0;
      en_t = 1'b1;
      for (int i = 0; i < 256 * 16; i++) begin
         @(negedge clk);
         if (fs_t) begin
            fs_n++;
            if (fc_t !== 8'(fs_n)) fc_bad++;
         end
      end
      en_t = 1'b0;
      chk("t_frame_starts", fs_n, 256);
      chk("t_frame_cnt_seq", fc_bad, 0);
      chk("t_frame_cnt_wrap", {ph_t, pv_t, fc_t}, {9'd0, 9'd0, 8'd0});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
